// File: rtl/collision_tracker.sv
// collision_tracker
// Detects overlap between a player pixel layer and a hazard pixel layer,
// turns the first overlap into a one-cycle hit pulse, and takes a life.
// Each hit is followed by an invulnerability window, or by DEAD when no
// lives remain.
// Optional feature macro: COLLISION_HIT_POS_EN. When defined, the block
// adds hit_row/hit_col ports. These report the overlapping pixel with the
// lowest row index, and the lowest column index within that row, captured
// on each hit.
module collision_tracker #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int LIVES    = 3,
    parameter int COOLDOWN = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ROWS-1:0][COLS-1:0]  GrnPixels,
    input  logic [ROWS-1:0][COLS-1:0]  RedPixels,
    input  logic                       enable,
    input  logic                       restart,
    output logic                       hit,
    output logic [$clog2(LIVES+1)-1:0] lives,
`ifdef COLLISION_HIT_POS_EN
    output logic                       game_over,
    output logic [$clog2(ROWS)-1:0]    hit_row,
    output logic [$clog2(COLS)-1:0]    hit_col
`else
    output logic                       game_over
`endif
);

    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int CNT_W   = $clog2(COOLDOWN + 1);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(COOLDOWN);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(1);
    localparam logic [LIVES_W-1:0] LIFE_ONE   = LIVES_W'(1);

    // Game states
    localparam logic [1:0] S_SAFE = 2'd0;
    localparam logic [1:0] S_HIT  = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;
    localparam logic [1:0] S_DEAD = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [LIVES_W-1:0]        r_lives;
    logic [LIVES_W-1:0]        w_lives_nxt;
    logic                      r_hit;
    logic                      w_hit_nxt;
    logic [ROWS-1:0][COLS-1:0] w_and;
    logic                      w_overlap;

    // Per-pixel coincidence of the two layers; any set bit is a collision.
    assign w_and     = GrnPixels & RedPixels;
    assign w_overlap = |w_and;

    // Next-state logic. Restart overrides every state, including a pending
    // overlap. Overlap is only looked at in SAFE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lives_nxt = r_lives;
        w_hit_nxt   = 1'b0;
        if (restart) begin
            w_state_nxt = S_SAFE;
            w_cnt_nxt   = '0;
            w_lives_nxt = LIVES_INIT;
        end else begin
            case (r_state)
                S_SAFE: begin
                    if (enable && w_overlap) begin
                        w_state_nxt = S_HIT;
                        w_hit_nxt   = 1'b1;
                        // Lives are never zero in SAFE, but guard against underflow anyway.
                        if (r_lives != '0) begin
                            w_lives_nxt = r_lives - LIFE_ONE;
                        end
                    end
                end
                S_HIT: begin
                    // HIT always lasts one cycle, even while paused.
                    if (r_lives == '0) begin
                        w_state_nxt = S_DEAD;
                    end else begin
                        w_state_nxt = S_COOL;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
                S_COOL: begin
                    if (enable) begin
                        if (r_cnt <= CNT_LAST) begin
                            w_state_nxt = S_SAFE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_LAST;
                        end
                    end
                end
                S_DEAD: begin
                    w_state_nxt = S_DEAD;
                end
                default: begin
                    w_state_nxt = S_SAFE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter, lives and pulse registers; reset wins over restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_SAFE;
            r_cnt   <= '0;
            r_lives <= LIVES_INIT;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lives <= w_lives_nxt;
            r_hit   <= w_hit_nxt;
        end
    end

    assign hit       = r_hit;
    assign lives     = r_lives;
    assign game_over = (r_state == S_DEAD);

`ifdef COLLISION_HIT_POS_EN
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic [ROW_W-1:0] w_enc_row;
    logic [COL_W-1:0] w_enc_col;
    logic             w_found;
    logic             w_capture;
    logic [ROW_W-1:0] r_hit_row;
    logic [COL_W-1:0] r_hit_col;

    // Priority encoder: the first set pixel in row-major scan order wins.
    always_comb begin
        w_found   = 1'b0;
        w_enc_row = '0;
        w_enc_col = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!w_found && w_and[r][c]) begin
                    w_found   = 1'b1;
                    w_enc_row = ROW_W'(r);
                    w_enc_col = COL_W'(c);
                end
            end
        end
    end

    // HIT is only entered from SAFE, so entering HIT marks the capture point.
    assign w_capture = (w_state_nxt == S_HIT) && (r_state == S_SAFE);

    // Position of the last hit; only reset clears it, restart keeps it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_row <= '0;
            r_hit_col <= '0;
        end else if (w_capture) begin
            r_hit_row <= w_enc_row;
            r_hit_col <= w_enc_col;
        end
    end

    assign hit_row = r_hit_row;
    assign hit_col = r_hit_col;
`endif

endmodule

// File: tb/tb_collision_tracker.sv
// tb_collision_tracker
// Scenario tasks plus a randomized run. They are checked against a
// behavioural game model: lives, a remaining-invulnerability count, and
// hit/dead flags.
`timescale 1ns/1ps
module tb_collision_tracker;

    localparam int ROWS     = 16;
    localparam int COLS     = 16;
    localparam int LIVES    = 3;
    localparam int COOLDOWN = 8;
    localparam int LW       = $clog2(LIVES + 1);

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      enable;
    logic                      restart;
    logic [ROWS-1:0][COLS-1:0] grn;
    logic [ROWS-1:0][COLS-1:0] red;
    logic                      hit;
    logic [LW-1:0]             lives;
    logic                      game_over;
`ifdef COLLISION_HIT_POS_EN
    logic [$clog2(ROWS)-1:0]   hit_row;
    logic [$clog2(COLS)-1:0]   hit_col;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int m_lives;
    int m_cool;
    int m_row;
    int m_col;
    bit m_hit;
    bit m_dead;

    collision_tracker #(
        .ROWS(ROWS), .COLS(COLS), .LIVES(LIVES), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .GrnPixels (grn),
        .RedPixels (red),
        .enable    (enable),
        .restart   (restart),
        .hit       (hit),
        .lives     (lives),
`ifdef COLLISION_HIT_POS_EN
        .game_over (game_over),
        .hit_row   (hit_row),
        .hit_col   (hit_col)
`else
        .game_over (game_over)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit find_overlap(output int fr, output int fc);
        fr = 0;
        fc = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (grn[r][c] && red[r][c]) begin
                    fr = r;
                    fc = c;
                    return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // Game rules applied to the inputs present at one clock edge
    task automatic model_edge();
        int fr, fc;
        bit ov;
        ov = find_overlap(fr, fc);
        cyc++;
        if (reset) begin
            m_lives = LIVES; m_hit = 0; m_cool = 0; m_dead = 0; m_row = 0; m_col = 0;
        end else if (restart) begin
            m_lives = LIVES; m_hit = 0; m_cool = 0; m_dead = 0;
        end else if (m_hit) begin
            m_hit = 0;
            if (m_lives == 0) m_dead = 1;
            else m_cool = COOLDOWN;
        end else if (m_dead) begin
            m_dead = 1;
        end else if (m_cool > 0) begin
            if (enable) m_cool--;
        end else if (enable && ov) begin
            m_hit = 1;
            if (m_lives > 0) m_lives--;
            m_row = fr;
            m_col = fc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Random background pixels that never coincide between layers
    task automatic set_noise();
        for (int r = 0; r < ROWS; r++) begin
            grn[r] = COLS'($urandom);
            red[r] = COLS'($urandom) & ~grn[r];
        end
    endtask

    task automatic share(input int r, input int c);
        grn[r][c] = 1'b1;
        red[r][c] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; restart = 1'b0; enable = 1'b0;
        set_noise();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; restart = 1'b0; enable = 1'b1;
        grn = '1; red = '1;
        step();
        step();
        checks++;
        if (hit !== 1'b0 || lives !== LW'(LIVES) || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hit=%b lives=%0d go=%b, expected 0/%0d/0", hit, lives, game_over, LIVES);
        end
`ifdef COLLISION_HIT_POS_EN
        checks++;
        if (hit_row !== '0 || hit_col !== '0) begin
            errors++;
            $display("FAIL reset_pos: row=%0d col=%0d, expected 0/0", hit_row, hit_col);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_single_hit();
        int  n;
        bit  got;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_noise();
            step();
            checks++;
            if (hit !== m_hit || lives !== LW'(m_lives) || game_over !== m_dead) begin
                errors++;
                $display("FAIL single_idle cyc %0d: hit=%b lives=%0d go=%b, expected %b/%0d/%b", cyc, hit, lives, game_over, m_hit, m_lives, m_dead);
            end
        end
        set_noise();
        share(5, 9);
        step();
        checks++;
        if (hit !== 1'b1 || lives !== LW'(LIVES - 1)) begin
            errors++;
            $display("FAIL single_pulse: hit=%b lives=%0d, expected 1/%0d", hit, lives, LIVES - 1);
        end
`ifdef COLLISION_HIT_POS_EN
        checks++;
        if (hit_row !== 4'd5 || hit_col !== 4'd9) begin
            errors++;
            $display("FAIL single_pos: row=%0d col=%0d, expected 5/9", hit_row, hit_col);
        end
`endif
        set_noise();
        step();
        checks++;
        if (hit !== 1'b0 || lives !== LW'(LIVES - 1)) begin
            errors++;
            $display("FAIL single_one_cycle: hit=%b lives=%0d, expected 0/%0d", hit, lives, LIVES - 1);
        end
        n = 1;
        got = 0;
        share(5, 9);
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            n++;
            checks++;
            if (hit !== m_hit || lives !== LW'(m_lives) || game_over !== m_dead) begin
                errors++;
                $display("FAIL single_cool cyc %0d: hit=%b lives=%0d go=%b, expected %b/%0d/%b", cyc, hit, lives, game_over, m_hit, m_lives, m_dead);
            end
            if (hit === 1'b1) got = 1;
        end
        checks++;
        if (!got || n != COOLDOWN + 2) begin
            errors++;
            $display("FAIL single_spacing: got=%0d after %0d cycles, expected hit after %0d", got, n, COOLDOWN + 2);
        end
    endtask

    task automatic test_persistent();
        int hc[$];
        int hl[$];
        do_reset();
        enable = 1'b1;
        set_noise();
        share(11, 14);
        for (int t = 1; t <= 60; t++) begin
            step();
            checks++;
            if (hit !== m_hit || lives !== LW'(m_lives) || game_over !== m_dead) begin
                errors++;
                $display("FAIL persist cyc %0d: hit=%b lives=%0d go=%b, expected %b/%0d/%b", cyc, hit, lives, game_over, m_hit, m_lives, m_dead);
            end
            if (hit === 1'b1) begin
                hc.push_back(t);
                hl.push_back(int'(lives));
            end
        end
        checks++;
        if (hc.size() != LIVES) begin
            errors++;
            $display("FAIL persist_count: %0d hits, expected %0d", hc.size(), LIVES);
        end
        foreach (hc[k]) begin
            checks++;
            if (hc[k] != 1 + 10 * k || hl[k] != LIVES - 1 - k) begin
                errors++;
                $display("FAIL persist_hit%0d: at %0d lives %0d, expected at %0d lives %0d", k, hc[k], hl[k], 1 + 10 * k, LIVES - 1 - k);
            end
        end
        checks++;
        if (game_over !== 1'b1 || lives !== '0) begin
            errors++;
            $display("FAIL persist_dead: go=%b lives=%0d, expected 1/0", game_over, lives);
        end
    endtask

    task automatic test_pause();
        int n;
        bit got;
        do_reset();
        enable = 1'b1;
        set_noise();
        share(2, 2);
        step();
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL pause_first_hit: hit=%b, expected 1", hit);
        end
        set_noise();
        n = 0;
        for (int i = 0; i < 3; i++) begin step(); n++; end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); n++; end
        enable = 1'b1;
        share(2, 2);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            n++;
            checks++;
            if (hit !== m_hit || lives !== LW'(m_lives) || game_over !== m_dead) begin
                errors++;
                $display("FAIL pause_cool cyc %0d: hit=%b lives=%0d go=%b, expected %b/%0d/%b", cyc, hit, lives, game_over, m_hit, m_lives, m_dead);
            end
            if (hit === 1'b1) got = 1;
        end
        checks++;
        if (!got || n != COOLDOWN + 2 + 5) begin
            errors++;
            $display("FAIL pause_spacing: got=%0d after %0d cycles, expected %0d", got, n, COOLDOWN + 7);
        end
        do_reset();
        enable = 1'b0;
        share(6, 6);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (hit !== 1'b0 || lives !== LW'(LIVES)) begin
                errors++;
                $display("FAIL pause_safe cyc %0d: hit=%b lives=%0d, expected 0/%0d", cyc, hit, lives, LIVES);
            end
        end
        enable = 1'b1;
        step();
        checks++;
        if (hit !== 1'b1 || lives !== LW'(LIVES - 1)) begin
            errors++;
            $display("FAIL pause_resume: hit=%b lives=%0d, expected 1/%0d", hit, lives, LIVES - 1);
        end
    endtask

    task automatic test_priority();
        do_reset();
        enable = 1'b1;
        set_noise();
        share(3, 12);
        share(3, 4);
        share(7, 0);
        step();
        checks++;
        if (hit !== 1'b1 || lives !== LW'(LIVES - 1)) begin
            errors++;
            $display("FAIL prio_hit: hit=%b lives=%0d, expected 1/%0d", hit, lives, LIVES - 1);
        end
`ifdef COLLISION_HIT_POS_EN
        checks++;
        if (hit_row !== 4'd3 || hit_col !== 4'd4) begin
            errors++;
            $display("FAIL prio_pos: row=%0d col=%0d, expected 3/4", hit_row, hit_col);
        end
`endif
    endtask

    task automatic test_restart_reset();
        bit dead;
        do_reset();
        enable = 1'b1;
        set_noise();
        share(1, 1);
        dead = 0;
        for (int i = 0; i < 60 && !dead; i++) begin
            step();
            if (game_over === 1'b1) dead = 1;
        end
        checks++;
        if (!dead || m_dead != 1'b1) begin
            errors++;
            $display("FAIL rr_reach_dead: go=%b, expected 1", game_over);
        end
        restart = 1'b1;
        step();
        checks++;
        if (hit !== 1'b0 || lives !== LW'(LIVES) || game_over !== 1'b0) begin
            errors++;
            $display("FAIL rr_restart: hit=%b lives=%0d go=%b, expected 0/%0d/0", hit, lives, game_over, LIVES);
        end
`ifdef COLLISION_HIT_POS_EN
        checks++;
        if (hit_row !== 4'd1 || hit_col !== 4'd1) begin
            errors++;
            $display("FAIL rr_pos_kept: row=%0d col=%0d, expected 1/1", hit_row, hit_col);
        end
`endif
        restart = 1'b0;
        step();
        checks++;
        if (hit !== 1'b1 || lives !== LW'(LIVES - 1)) begin
            errors++;
            $display("FAIL rr_rehit: hit=%b lives=%0d, expected 1/%0d", hit, lives, LIVES - 1);
        end
        reset = 1'b1;
        step();
        checks++;
        if (hit !== 1'b0 || lives !== LW'(LIVES)) begin
            errors++;
            $display("FAIL rr_reset_in_hit: hit=%b lives=%0d, expected 0/%0d", hit, lives, LIVES);
        end
        reset = 1'b0;
        set_noise();
        step();
        checks++;
        if (hit !== 1'b0 || lives !== LW'(LIVES)) begin
            errors++;
            $display("FAIL rr_no_pulse: hit=%b lives=%0d, expected 0/%0d", hit, lives, LIVES);
        end
        share(9, 3);
        step();
        set_noise();
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        share(9, 3);
        step();
        checks++;
        if (hit !== 1'b1 || lives !== LW'(LIVES - 1)) begin
            errors++;
            $display("FAIL rr_reset_mid_cool: hit=%b lives=%0d, expected 1/%0d", hit, lives, LIVES - 1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 59) == 0);
            reset   = ($urandom_range(0, 99) == 0);
            set_noise();
            if ($urandom_range(0, 2) == 0) share($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
            if ($urandom_range(0, 3) == 0) share($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
            step();
            checks++;
            if (hit !== m_hit || lives !== LW'(m_lives) || game_over !== m_dead) begin
                errors++;
                $display("FAIL random cyc %0d: hit=%b lives=%0d go=%b, expected %b/%0d/%b", cyc, hit, lives, game_over, m_hit, m_lives, m_dead);
            end
`ifdef COLLISION_HIT_POS_EN
            checks++;
            if (int'(hit_row) != m_row || int'(hit_col) != m_col) begin
                errors++;
                $display("FAIL random_pos cyc %0d: row=%0d col=%0d, expected %0d/%0d", cyc, hit_row, hit_col, m_row, m_col);
            end
`endif
        end
        reset = 1'b0;
        restart = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; restart = 1'b0;
        grn = '0; red = '0;
        m_lives = LIVES; m_cool = 0; m_row = 0; m_col = 0; m_hit = 0; m_dead = 0;
        test_reset();
        test_single_hit();
        test_persistent();
        test_pause();
        test_priority();
        test_restart_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_tracker.md
COLLISION_TRACKER -- requirements
Module: collision_tracker

Interface
REQ-001 Parameter ROWS, default 16: pixel-matrix row count; SHALL be at least 2.
REQ-002 Parameter COLS, default 16: pixel-matrix column count; SHALL be at least 2.
REQ-003 Parameter LIVES, default 3: lives loaded at reset and restart; SHALL be at least 1.
REQ-004 Parameter COOLDOWN, default 8: invulnerability length in enabled cycles; SHALL be at least 1.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port GrnPixels, input, [ROWS-1:0][COLS-1:0]: player-layer pixels.
REQ-008 Port RedPixels, input, [ROWS-1:0][COLS-1:0]: hazard-layer pixels.
REQ-009 Port enable, input, 1 bit: game-running qualifier; low SHALL pause detection and cooldown.
REQ-010 Port restart, input, 1 bit: reloads lives and returns to SAFE.
REQ-011 Port hit, output, 1 bit: one-cycle pulse per registered collision.
REQ-012 Port lives, output, $clog2(LIVES+1) bits: remaining lives.
REQ-013 Port game_over, output, 1 bit: high while in DEAD.
REQ-014 Port hit_row, output, $clog2(ROWS) bits: row of the last registered collision (see REQ-030).
REQ-015 Port hit_col, output, $clog2(COLS) bits: column of the last registered collision (see REQ-030).

Function
REQ-016 overlap SHALL be combinational: the OR over all r,c of (GrnPixels[r][c] AND RedPixels[r][c]).
REQ-017 The FSM SHALL have exactly four states: SAFE, HIT, COOLDOWN, DEAD.
REQ-018 SAFE SHALL go to HIT when enable=1 and overlap=1, and SHALL otherwise stay in SAFE.
REQ-019 On SAFE->HIT, lives SHALL decrement by 1, with the new value visible during the HIT cycle.
REQ-020 HIT SHALL last exactly one cycle, with hit=1 only in that cycle.
REQ-021 After HIT, the next state SHALL be DEAD if lives==0, else COOLDOWN.
REQ-022 Latency: overlap sampled at edge N SHALL give hit=1 between edges N and N+1.
REQ-023 On HIT->COOLDOWN, the cooldown counter SHALL load COOLDOWN.
REQ-024 In COOLDOWN, the counter SHALL decrement on each enabled cycle.
REQ-025 COOLDOWN SHALL go to SAFE on the enabled cycle in which the counter equals 1, so the block stays exactly COOLDOWN enabled cycles in COOLDOWN.
REQ-026 overlap SHALL be ignored in COOLDOWN, HIT and DEAD.
REQ-027 When enable=0, state and counter SHALL hold in SAFE and COOLDOWN; HIT SHALL still complete its single cycle.
REQ-028 If overlap persists after cooldown, a new HIT SHALL occur on the first enabled SAFE cycle.
REQ-029 restart=1 SHALL, in any state, set the state to SAFE, lives to LIVES, counter to 0 and hit to 0 on the next edge; restart SHALL win over a simultaneous overlap.
REQ-030 hit_row and hit_col SHALL capture the overlapping pixel with the lowest row index, and the lowest column index within that row, on SAFE->HIT; they SHALL hold until the next HIT and SHALL NOT be cleared by restart.
REQ-031 lives SHALL never underflow; DEAD SHALL be left only by reset or restart.

Reset
REQ-032 reset SHALL have priority over restart and enable.
REQ-033 On reset the block SHALL set: state=SAFE, hit=0, lives=LIVES, game_over=0, counter=0, hit_row=0, hit_col=0.
REQ-034 reset asserted mid-COOLDOWN or in HIT SHALL abandon the event, with no pulse on the following cycle.

Configuration
REQ-035 Macro COLLISION_HIT_POS_EN: when defined, hit_row/hit_col and their priority encoder SHALL be present as in REQ-030.
REQ-036 When COLLISION_HIT_POS_EN is undefined, hit_row and hit_col SHALL be removed from the port list, with all other behaviour unchanged.

Verification
REQ-037 Single-hit scenario: reset, then enable=1, one shared pixel at [5][9] for 1 cycle -> hit pulse 1 cycle later, lives 3->2, hit_row=5, hit_col=9, then 8 COOLDOWN cycles, then SAFE.
REQ-038 Persistent overlap: overlap held continuously -> hits spaced 10 cycles apart (HIT + 8 COOLDOWN + SAFE), lives 3,2,1,0, then game_over=1 with no further hits.
REQ-039 Pause: enable=0 for 5 cycles mid-COOLDOWN -> COOLDOWN exit delayed by exactly 5 cycles; enable=0 with overlap in SAFE -> no hit.
REQ-040 Priority encoding: overlaps at [3][12] and [3][4] and [7][0] in the same cycle -> hit_row=3, hit_col=4.
REQ-041 Restart and reset: in DEAD, restart=1 with overlap present -> SAFE, lives=3, no hit that cycle; reset asserted during HIT -> hit=0 and lives=3 next cycle.
